// File: rtl/data_bus_bridge.sv
// Bridges core load/store requests onto a single-beat valid/ready data bus, stalling the core until the transfer retires.
// Optional BUS_TIMEOUT_EN macro adds an abort after TIMEOUT_CYCLES un-acknowledged bus cycles.
module data_bus_bridge #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_re,
   input  logic        mem_we,
   input  logic [2:0]  mem_ctrl,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        err,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata
);
   // state | meaning
   // IDLE  | waiting for a core request
   // BUS   | request on the bus, waiting for bus_ready
   // DONE  | core released for one cycle, err flags misalign/timeout
   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

   state_t      state, state_nxt;
   logic        req, is_byte, is_half, misalign, timeout;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [29:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q, rdata_q;
   logic        we_q, err_q;
   logic        unused_bits;

   assign req      = mem_re | mem_we;
   // Size comes from the low two bits alone; bit 2 only selects sign handling in the core.
   assign is_byte  = (mem_ctrl[1:0] == 2'b00);
   assign is_half  = (mem_ctrl[1:0] == 2'b01);
   assign misalign = (is_half & addr[0]) | (~is_byte & ~is_half & (addr[1:0] != 2'b00));
   assign unused_bits = mem_ctrl[2];

   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = wdata;
      if (mem_we) begin
         if (is_byte) begin
            be_nxt    = 4'b0001 << addr[1:0];
            wdata_nxt = {4{wdata[7:0]}};
         end else if (is_half) begin
            be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{wdata[15:0]}};
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt;

   // Every BUS entry passes through IDLE, so clearing there restarts the count per transfer.
   always_ff @(posedge clk) begin
      if (reset)
         tmo_cnt <= '0;
      else if (state == IDLE)
         tmo_cnt <= '0;
      else if (state == BUS && !bus_ready)
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign timeout = (state == BUS) && !bus_ready && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES > 0);
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = misalign ? DONE : BUS;
         BUS:     if (bus_ready || timeout) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stall     = (state == BUS) || ((state == IDLE) && req);
      bus_valid = (state == BUS);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (state == IDLE && req) begin
            addr_q  <= addr[31:2];
            be_q    <= be_nxt;
            wdata_q <= wdata_nxt;
            we_q    <= mem_we;
            if (misalign) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
         end
         if (state == BUS) begin
            if (bus_ready) begin
               if (!we_q) rdata_q <= bus_rdata;
            end else if (timeout) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
         end
      end
   end

   assign err       = err_q;
   assign rdata     = rdata_q;
   assign bus_we    = we_q;
   assign bus_addr  = {addr_q, 2'b00};
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;
endmodule

// File: tb/tb_data_bus_bridge.sv
// Testbench for data_bus_bridge: directed vector table, randomized accesses against a spec-level model,
// and hand sequences for reset-during-BUS and the timeout / no-timeout behaviour.
module tb_data_bus_bridge;
   logic        clk = 1'b0;
   logic        reset, mem_re, mem_we, bus_ready;
   logic [2:0]  mem_ctrl;
   logic [31:0] addr, wdata, bus_rdata;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic        stall, err, bus_valid, bus_we;
   logic [3:0]  bus_be;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_rd;

   always #5 clk = ~clk;

   data_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .mem_re(mem_re), .mem_we(mem_we), .mem_ctrl(mem_ctrl),
      .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic        re;
      logic        we;
      logic [2:0]  ctrl;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] brd;
      int          delay;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic        e_mis;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: sizes, lanes and alignment taken straight from the access rules.
   function automatic vec_t model(input logic re, input logic we, input logic [2:0] ctrl,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] brd, input int delay, input logic [31:0] prev_rd);
      vec_t v;
      int   size_bytes;
      int   ofs;
      v.re = re; v.we = we; v.ctrl = ctrl; v.a = a; v.wd = wd; v.brd = brd; v.delay = delay;
      case (ctrl)
         3'b000, 3'b100: size_bytes = 1;
         3'b001, 3'b101: size_bytes = 2;
         default:        size_bytes = 4;
      endcase
      ofs = int'(a % 4);
      v.e_mis = (ofs % size_bytes) != 0;
      v.e_be  = 4'b1111;
      v.e_wd  = wd;
      if (we) begin
         v.e_be = 4'b0000;
         for (int b = 0; b < 4; b++)
            if (b >= ofs && b < ofs + size_bytes) v.e_be[b] = 1'b1;
         for (int b = 0; b < 4; b++)
            v.e_wd[8*b +: 8] = wd[8*(b % size_bytes) +: 8];
      end
      if (v.e_mis)  v.e_rd = 32'h0;
      else if (we)  v.e_rd = prev_rd;
      else          v.e_rd = brd;
      return v;
   endfunction

   // Entered and left at 1 time unit after a rising edge, in an IDLE cycle.
   task automatic do_access(input vec_t v, input string tag);
      int nst = 0;
      mem_re = v.re; mem_we = v.we; mem_ctrl = v.ctrl; addr = v.a; wdata = v.wd;
      bus_rdata = v.brd; bus_ready = 1'b0;
      #1;
      chk({tag, " req_valid"}, bus_valid, 1'b0);
      nst += int'(stall);
      @(posedge clk); #1;
      mem_re = 1'b0; mem_we = 1'b0;
      addr = $urandom; wdata = $urandom;
      if (!v.e_mis) begin
         for (int k = 0; k <= v.delay; k++) begin
            bus_ready = (k == v.delay);
            #1;
            chk({tag, " bus_valid"}, bus_valid, 1'b1);
            chk({tag, " bus_addr"}, bus_addr, v.a & 32'hFFFF_FFFC);
            chk({tag, " bus_be"}, bus_be, v.e_be);
            chk({tag, " bus_we"}, bus_we, v.we);
            if (v.we) chk({tag, " bus_wdata"}, bus_wdata, v.e_wd);
            nst += int'(stall);
            @(posedge clk); #1;
         end
         bus_ready = 1'b0;
      end
      #1;
      chk({tag, " done_stall"}, stall, 1'b0);
      chk({tag, " done_valid"}, bus_valid, 1'b0);
      chk({tag, " done_err"}, err, v.e_mis);
      chk({tag, " done_rdata"}, rdata, v.e_rd);
      chk({tag, " stall_cycles"}, nst, v.e_mis ? 1 : 2 + v.delay);
      @(posedge clk); #1;
      chk({tag, " idle_err"}, err, 1'b0);
   endtask

   initial begin
      reset = 1'b1; mem_re = 1'b0; mem_we = 1'b0; mem_ctrl = 3'b000;
      addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
      repeat (3) @(posedge clk);
      #1; reset = 1'b0; #1;
      chk("rst stall", stall, 1'b0);
      chk("rst err", err, 1'b0);
      chk("rst bus_valid", bus_valid, 1'b0);
      chk("rst bus_we", bus_we, 1'b0);
      chk("rst bus_be", bus_be, 4'b0);
      chk("rst bus_addr", bus_addr, 32'h0);
      chk("rst bus_wdata", bus_wdata, 32'h0);
      chk("rst rdata", rdata, 32'h0);
      @(posedge clk); #1;

      //          re    we    ctrl    addr          wdata         bus_rdata     dly  be       wdata exp     mis   rdata exp
      tv[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF};
      tv[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0,        0, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF};
      tv[2]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h0000_1234, 32'h0,        3, 4'b1100, 32'h1234_1234, 1'b0, 32'hDEAD_BEEF};
      tv[3]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h7777_7777, 0, 4'b1111, 32'h0,        1'b1, 32'h0};
      tv[4]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0105, 32'h0,        32'h1122_3344, 1, 4'b1111, 32'h0,        1'b0, 32'h1122_3344};
      tv[5]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0301, 32'h0000_5555, 32'h0,        0, 4'b0110, 32'h5555_5555, 1'b1, 32'h0};
      tv[6]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
      tv[7]  = '{1'b1, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_005A, 32'h9999_9999, 0, 4'b0010, 32'h5A5A_5A5A, 1'b0, 32'h0};
      tv[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h0BAD_F00D, 2, 4'b1111, 32'h0,        1'b0, 32'h0BAD_F00D};
      tv[9]  = '{1'b0, 1'b1, 3'b111, 32'h0000_0022, 32'h1111_2222, 32'h0,        0, 4'b1111, 32'h1111_2222, 1'b1, 32'h0};
      tv[10] = '{1'b0, 1'b1, 3'b011, 32'h0000_0024, 32'h8765_4321, 32'h0,        0, 4'b1111, 32'h8765_4321, 1'b0, 32'h0};
      tv[11] = '{1'b0, 1'b1, 3'b101, 32'h0000_0500, 32'hABCD_9876, 32'h0,        2, 4'b0011, 32'h9876_9876, 1'b0, 32'h0};
      for (int i = 0; i < 12; i++) do_access(tv[i], $sformatf("vec%0d", i));
      exp_rd = tv[11].e_rd;

      for (int n = 0; n < 200; n++) begin
         vec_t v;
         int   kind;
         kind = $urandom_range(0, 2);
         v = model(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 3), exp_rd);
         do_access(v, $sformatf("rnd%0d", n));
         exp_rd = v.e_rd;
         if ($urandom_range(0, 3) == 0) begin
            #1;
            chk("rnd idle_stall", stall, 1'b0);
            chk("rnd idle_valid", bus_valid, 1'b0);
            chk("rnd idle_rdata", rdata, exp_rd);
            @(posedge clk); #1;
         end
      end

      // Reset asserted in the second BUS cycle abandons the transfer.
      do_access(model(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h55AA_55AA, 0, exp_rd), "preload");
      mem_re = 1'b1; mem_ctrl = 3'b010; addr = 32'h0000_0604; bus_ready = 1'b0;
      #1; chk("rstbus req_stall", stall, 1'b1);
      @(posedge clk); #1; mem_re = 1'b0;
      #1; chk("rstbus bus1_valid", bus_valid, 1'b1);
      @(posedge clk); #1; reset = 1'b1;
      #1; chk("rstbus bus2_valid", bus_valid, 1'b1);
      @(posedge clk); #1; reset = 1'b0;
      #1;
      chk("rstbus after_valid", bus_valid, 1'b0);
      chk("rstbus after_stall", stall, 1'b0);
      chk("rstbus after_rdata", rdata, 32'h0);
      bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #2;
         chk("rstbus late_valid", bus_valid, 1'b0);
         chk("rstbus late_stall", stall, 1'b0);
         chk("rstbus late_rdata", rdata, 32'h0);
         chk("rstbus late_err", err, 1'b0);
      end
      bus_ready = 1'b0;
      @(posedge clk); #1;

      // Bus never answers.
      do_access(model(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 32'h1357_9BDF, 0, 32'h0), "preload2");
      mem_re = 1'b1; mem_ctrl = 3'b010; addr = 32'h0000_0704; bus_ready = 1'b0;
      #1; chk("tmo req_stall", stall, 1'b1);
      @(posedge clk); #1; mem_re = 1'b0;
`ifdef BUS_TIMEOUT_EN
      for (int k = 0; k < 4; k++) begin
         #1; chk("tmo bus_valid", bus_valid, 1'b1);
         @(posedge clk); #1;
      end
      #1;
      chk("tmo done_valid", bus_valid, 1'b0);
      chk("tmo done_err", err, 1'b1);
      chk("tmo done_rdata", rdata, 32'h0);
      chk("tmo done_stall", stall, 1'b0);
      @(posedge clk); #1;
`else
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("notmo stall", stall, 1'b1);
         chk("notmo bus_valid", bus_valid, 1'b1);
         chk("notmo err", err, 1'b0);
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      #1; chk("notmo recover_valid", bus_valid, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
